// File: rtl/seg7_scan_controller.sv
// Four-digit seven-segment scan controller: latches a BCD frame, then time-multiplexes
// the shared segment bus over four common-anode digits with a dark guard at each slot start.
module seg7_scan_controller #(
    parameter int DIGIT_TICKS = 100000,
    parameter int GUARD_TICKS = 1000,
    parameter int LZ_BLANK    = 1
) (
    input  logic        clock_100Mhz,
    input  logic        reset,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        blank,
    output logic        frame_start,
    output logic [3:0]  anode,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int            CW        = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(DIGIT_TICKS - 1);
    localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD_TICKS);
    localparam bit            LZ_EN     = (LZ_BLANK != 0);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [15:0]   r_sh_digits;
    logic [3:0]    r_sh_dp;
    logic          r_sh_blank;
    logic          r_load_pending;
    logic          r_frame_start;
    logic [3:0]    r_anode;
    logic [6:0]    r_seg;
    logic          r_dp;

    logic          w_tick;
    logic          w_capture;
    logic [3:0]    w_nib;
    logic [6:0]    w_seg_next;
    logic [3:0]    w_zero;
    logic [3:0]    w_lz;
    logic          w_dark;
    logic [3:0]    w_anode_next;

    assign w_tick    = (r_cnt == CNT_MAX);
    // A capture either starts the very first frame after reset or closes the last slot of a frame.
    assign w_capture = r_load_pending || (w_tick && (r_idx == 2'd3));

    assign w_nib = r_sh_digits[{r_idx, 2'b00} +: 4];

    always_comb begin
        w_seg_next = 7'b0111111;
        case (w_nib)
            4'd0:    w_seg_next = 7'b1000000;
            4'd1:    w_seg_next = 7'b1111001;
            4'd2:    w_seg_next = 7'b0100100;
            4'd3:    w_seg_next = 7'b0110000;
            4'd4:    w_seg_next = 7'b0011001;
            4'd5:    w_seg_next = 7'b0010010;
            4'd6:    w_seg_next = 7'b0000010;
            4'd7:    w_seg_next = 7'b1111000;
            4'd8:    w_seg_next = 7'b0000000;
            4'd9:    w_seg_next = 7'b0010000;
            default: w_seg_next = 7'b0111111;
        endcase
    end

    assign w_zero[0] = (r_sh_digits[3:0]   == 4'd0);
    assign w_zero[1] = (r_sh_digits[7:4]   == 4'd0);
    assign w_zero[2] = (r_sh_digits[11:8]  == 4'd0);
    assign w_zero[3] = (r_sh_digits[15:12] == 4'd0);

    // A digit is a leading zero only if it and every more significant digit are zero;
    // the rightmost digit always shows so a value of zero still reads "0".
    assign w_lz[3] = LZ_EN && w_zero[3];
    assign w_lz[2] = LZ_EN && w_zero[3] && w_zero[2];
    assign w_lz[1] = LZ_EN && w_zero[3] && w_zero[2] && w_zero[1];
    assign w_lz[0] = 1'b0;

    assign w_dark       = r_sh_blank || w_lz[r_idx] || (r_cnt < CNT_GUARD);
    assign w_anode_next = w_dark ? 4'b1111 : ~(4'b0001 << r_idx);

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            r_cnt          <= '0;
            r_idx          <= 2'd0;
            r_sh_digits    <= 16'h0000;
            r_sh_dp        <= 4'b0000;
            r_sh_blank     <= 1'b1;
            r_load_pending <= 1'b1;
            r_frame_start  <= 1'b0;
        end else begin
            r_frame_start <= w_capture;
            if (w_capture) begin
                r_sh_digits    <= digits_in;
                r_sh_dp        <= dp_in;
                r_sh_blank     <= blank;
                r_load_pending <= 1'b0;
            end
            // The first-capture edge holds the counter at zero so slot 0 starts with a full guard.
            if (!r_load_pending) begin
                if (w_tick) begin
                    r_cnt <= '0;
                    r_idx <= r_idx + 2'd1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            r_anode <= 4'b1111;
            r_seg   <= 7'b1111111;
            r_dp    <= 1'b1;
        end else begin
            r_anode <= w_anode_next;
            r_seg   <= w_seg_next;
            r_dp    <= ~r_sh_dp[r_idx];
        end
    end

    assign frame_start = r_frame_start;
    assign anode       = r_anode;
    assign seg         = r_seg;
    assign dp          = r_dp;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed bench for seg7_scan_controller (DIGIT_TICKS=8, GUARD_TICKS=2): per-vector
// slot tables plus hand-written sequences for frame timing, mid-frame changes, blank and reset.
module tb_seg7_scan_controller;

  localparam int DT = 8;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111;
  localparam logic [15:0] AN_SCAN = 16'h7BDE;

  logic        clk;
  logic        reset;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        blank;
  logic        frame_start;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic        fs_nolz;
  logic [3:0]  anode_nolz;
  logic [6:0]  seg_nolz;
  logic        dp_nolz;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  dpv;
    logic        blk;
    logic [15:0] an;       // {slot3, slot2, slot1, slot0}
    logic [27:0] sg;
    logic [3:0]  dpo;
    logic [15:0] an_nolz;
  } vec_t;

  vec_t vecs[8];
  int   lo[4];
  int   dark_cnt;
  int   multi_cnt;

  seg7_scan_controller #(.DIGIT_TICKS(DT), .GUARD_TICKS(2), .LZ_BLANK(1)) dut (
    .clock_100Mhz(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in), .blank(blank),
    .frame_start(frame_start), .anode(anode), .seg(seg), .dp(dp)
  );

  seg7_scan_controller #(.DIGIT_TICKS(DT), .GUARD_TICKS(2), .LZ_BLANK(0)) dut_nolz (
    .clock_100Mhz(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in), .blank(blank),
    .frame_start(fs_nolz), .anode(anode_nolz), .seg(seg_nolz), .dp(dp_nolz)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reset for one edge with the new inputs set up; returns just after the capture edge.
  task automatic apply_capture(input logic [15:0] d, input logic [3:0] p, input logic b);
    reset = 1'b1;
    digits_in = d;
    dp_in = p;
    blank = b;
    step(1);
    reset = 1'b0;
    step(1);
  endtask

  task automatic wait_frame(output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (frame_start !== 1'b1 && n < 200);
  endtask

  task automatic frame_stats(input int drop_blank_at);
    for (int j = 0; j < 4; j++) lo[j] = 0;
    dark_cnt = 0;
    multi_cnt = 0;
    for (int s = 1; s <= 4 * DT; s++) begin
      step(1);
      for (int j = 0; j < 4; j++) if (anode[j] == 1'b0) lo[j]++;
      if (anode == 4'b1111) dark_cnt++;
      if ($countones(~anode) > 1) multi_cnt++;
      if (s == drop_blank_at) blank = 1'b0;
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    digits_in = 16'h0000;
    dp_in = 4'b0000;
    blank = 1'b0;

    vecs[0] = '{16'h1234, 4'b0000, 1'b0, AN_SCAN,  {S1, S2, S3, S4}, 4'b1111, AN_SCAN};
    vecs[1] = '{16'h0005, 4'b0000, 1'b0, 16'hFFFE, {S0, S0, S0, S5}, 4'b1111, AN_SCAN};
    vecs[2] = '{16'h0000, 4'b0000, 1'b0, 16'hFFFE, {S0, S0, S0, S0}, 4'b1111, AN_SCAN};
    vecs[3] = '{16'h00A0, 4'b0010, 1'b0, 16'hFFDE, {S0, S0, SD, S0}, 4'b1101, AN_SCAN};
    vecs[4] = '{16'h1234, 4'b1111, 1'b1, 16'hFFFF, {S1, S2, S3, S4}, 4'b0000, 16'hFFFF};
    vecs[5] = '{16'h9876, 4'b1001, 1'b0, AN_SCAN,  {S9, S8, S7, S6}, 4'b0110, AN_SCAN};
    vecs[6] = '{16'h1F00, 4'b0100, 1'b0, AN_SCAN,  {S1, SD, S0, S0}, 4'b1011, AN_SCAN};
    vecs[7] = '{16'h0B07, 4'b0000, 1'b0, 16'hFBDE, {S0, SD, S0, S7}, 4'b1111, AN_SCAN};

    step(2);
    check("reset_anode", 32'(anode), 32'hF);
    check("reset_seg", 32'(seg), 32'h7F);
    check("reset_dp", 32'(dp), 32'h1);
    check("reset_fs", 32'(frame_start), 32'h0);

    // Table: sample the middle of each slot of the first frame after capture.
    for (int i = 0; i < 8; i++) begin
      apply_capture(vecs[i].digits, vecs[i].dpv, vecs[i].blk);
      check($sformatf("v%0d_fs", i), 32'(frame_start), 32'h1);
      step(5);
      for (int j = 0; j < 4; j++) begin
        check($sformatf("v%0d_an%0d", i, j), 32'(anode), 32'(vecs[i].an[j*4 +: 4]));
        check($sformatf("v%0d_seg%0d", i, j), 32'(seg), 32'(vecs[i].sg[j*7 +: 7]));
        check($sformatf("v%0d_dp%0d", i, j), 32'(dp), 32'(vecs[i].dpo[j]));
        check($sformatf("v%0d_nolz_an%0d", i, j), 32'(anode_nolz), 32'(vecs[i].an_nolz[j*4 +: 4]));
        if (j < 3) step(DT);
      end
    end

    // Basic scan timing: guard before first drive, frame period, duty per anode.
    apply_capture(16'h1234, 4'b0000, 1'b0);
    check("basic_fs", 32'(frame_start), 32'h1);
    step(1);
    check("basic_fs_one_cycle", 32'(frame_start), 32'h0);
    step(1);
    check("guard_dark", 32'(anode), 32'hF);
    step(1);
    check("first_low", 32'(anode), 32'hE);
    wait_frame(n);
    check("frame_period", 32'(3 + n), 32'd32);
    frame_stats(-1);
    for (int j = 0; j < 4; j++) check($sformatf("low_cycles%0d", j), 32'(lo[j]), 32'd6);
    check("dark_cycles", 32'(dark_cnt), 32'd8);
    check("one_hot", 32'(multi_cnt), 32'd0);
    check("frame_period2", 32'(frame_start), 32'h1);

    // Mid-frame input change is held off until the next frame.
    step(17);
    digits_in = 16'h9876;
    step(12);
    check("midchg_old_an", 32'(anode), 32'h7);
    check("midchg_old_seg", 32'(seg), 32'(S1));
    wait_frame(n);
    check("midchg_wait", 32'(n), 32'd3);
    step(5);
    check("midchg_new_an", 32'(anode), 32'hE);
    check("midchg_new_seg", 32'(seg), 32'(S6));

    // Blank raised mid-frame takes effect at the next frame; dropped, resumes a frame later.
    step(12);
    blank = 1'b1;
    step(12);
    check("blank_pending_an", 32'(anode), 32'h7);
    check("blank_pending_seg", 32'(seg), 32'(S9));
    wait_frame(n);
    check("blank_wait", 32'(n), 32'd3);
    frame_stats(16);
    check("blank_dark", 32'(lo[0] + lo[1] + lo[2] + lo[3]), 32'd0);
    check("blank_fs", 32'(frame_start), 32'h1);
    frame_stats(-1);
    check("blank_resume", 32'(lo[0] + lo[1] + lo[2] + lo[3]), 32'd24);
    check("blank_resume_one_hot", 32'(multi_cnt), 32'd0);

    // Reset for one cycle with idx=2, cnt=5.
    step(21);
    check("pre_reset_an", 32'(anode), 32'hB);
    reset = 1'b1;
    step(1);
    check("midrst_anode", 32'(anode), 32'hF);
    check("midrst_seg", 32'(seg), 32'h7F);
    check("midrst_dp", 32'(dp), 32'h1);
    check("midrst_fs", 32'(frame_start), 32'h0);
    reset = 1'b0;
    step(1);
    check("midrst_capture_fs", 32'(frame_start), 32'h1);
    step(2);
    check("midrst_guard", 32'(anode), 32'hF);
    step(1);
    check("midrst_restart_an", 32'(anode), 32'hE);
    check("midrst_restart_seg", 32'(seg), 32'(S6));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
